pudding_dac_loader: RTL and testbench
=====================================

# pudding_dac_loader

Upstream sequencer for the PUDDING 128-cell DAC daisychain. It accepts a parallel DAC code over a valid/ready handshake and expands it to a 128-bit thermometer pattern. The pattern is serialized onto the chain's `datum`/`shift` control pins, and a single `transfer` pulse with `dir=1` then commits it to the DAC state register. It also issues state-to-chain readback transfers (`dir=0`) on request, so the chain's parallel tap can be observed.

## Interface
Parameters:
- `CHAIN_LEN`, 128: number of daisychain cells. This is the count of shift cycles per load.
- `CODE_W`, 8: code width. It must satisfy 2^CODE_W > CHAIN_LEN.

Ports:
- `clk`  in  1  clock; the single clock domain. All outputs are registered on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `code_i`  in  CODE_W  requested number of active DAC cells.
- `valid_i`  in  1  `code_i` valid.
- `ready_o`  out  1  loader idle; a load or readback can be accepted.
- `rdbk_i`  in  1  readback request; sampled only while `ready_o=1`.
- `datum_o`  out  1  serial data to the chain, driving `ui_in[0]`.
- `shift_o`  out  1  chain shift enable, driving `ui_in[1]`.
- `transfer_o`  out  1  chain transfer strobe, driving `ui_in[2]`.
- `dir_o`  out  1  transfer direction, driving `ui_in[3]`. 1 = chain→state; 0 = state→chain.
- `done_o`  out  1  one-cycle pulse when a load or readback completes.
- `code_o`  out  CODE_W  last committed, clamped code. Updated only when the load's transfer is issued.

## Operation
- FSM states: IDLE, SHIFT, XFER, DONE.
- Reset values: state IDLE; `datum_o`, `shift_o`, `transfer_o`, `dir_o`, `done_o` = 0; `code_o` = 0; bit counter = 0.
- `ready_o` = (state==IDLE) & ~`rst`.
- IDLE with `valid_i`:
  - Handshake completes.
  - Latch `code_q = min(code_i, CHAIN_LEN)`.
  - Clear counter `k`; go to SHIFT.
- IDLE with `rdbk_i` and no `valid_i`: go to XFER with readback flag set.
- IDLE with both `valid_i` and `rdbk_i`: the load wins. The readback is dropped, not queued.
- SHIFT lasts exactly CHAIN_LEN cycles:
  - `shift_o=1` on every one of them.
  - `datum_o = (k >= CHAIN_LEN - code_q)`, for k = 0..CHAIN_LEN-1.
  - Zeros are sent first, then `code_q` ones. After the last shift, chain bits [code_q-1:0] are 1 and all others are 0.
  - When k = CHAIN_LEN-1, go to XFER.
- XFER lasts one cycle: `transfer_o=1`, `shift_o=0`, `datum_o=0`.
  - Load: `dir_o=1`, and `code_o <= code_q`.
  - Readback: `dir_o=0`, and `code_o` is unchanged.
- DONE lasts one cycle: `done_o=1`, all chain controls 0; return to IDLE.
- `valid_i` and `rdbk_i` are ignored outside IDLE. `code_i` may change freely after acceptance.
- `shift_o` and `transfer_o` are never high in the same cycle. This matters because the chain gives `transfer` priority over `shift`.
- `dir_o` holds its last XFER value while idle. `transfer_o=0` makes it don't-care at the chain.

## Timing
- Load, with handshake at edge 0:
  - SHIFT outputs are valid in cycles 1..CHAIN_LEN.
  - `transfer_o` is high in cycle CHAIN_LEN+1.
  - `done_o` is high in cycle CHAIN_LEN+2.
  - `ready_o` rises in cycle CHAIN_LEN+3.
  - Throughput is one load per CHAIN_LEN+3 cycles; 131 cycles at default.
- Readback: XFER in cycle 1, DONE in cycle 2, ready again in cycle 3.
- Asynchronous `rst` mid-operation:
  - All outputs drop to their reset values immediately, without waiting for a clock.
  - The partial load is abandoned and `code_o` is not updated.
  - The first handshake is possible at the first rising edge after `rst` deasserts.
- Clamp: `code_i` ≥ CHAIN_LEN yields all ones. `code_i` = 0 yields CHAIN_LEN zeros, and the transfer is still issued.

## Test plan
- Reset, then load code 5:
  - Exactly 128 `shift_o` cycles, with `datum_o` = 0 for k=0..122 and 1 for k=123..127.
  - One `transfer_o` with `dir_o=1`, then `done_o`, and `code_o`=5.
  - A chain model attached to the outputs holds state = 128'h1F.
- Edge codes:
  - Code 0 → state all-zero, `code_o`=0.
  - Code 128 → all ones.
  - Code 200 → all ones, `code_o`=128.
- Back-to-back: hold `valid_i` high with codes 3 then 7.
  - Second acceptance lands exactly 131 cycles after the first.
  - No overlap between `shift_o` and `transfer_o`; final state = 128'h7F.
- Readback: after loading 10, pulse `rdbk_i`.
  - `transfer_o` with `dir_o=0` in cycle 1, `done_o` in cycle 2.
  - The chain model's daisychain equals 128'h3FF and `code_o` stays 10.
- Simultaneous `valid_i`=1 (code 4) and `rdbk_i`=1 in IDLE → a load of 4 occurs and no readback transfer is issued.
- Assert `rst` asynchronously at SHIFT k=60 → all outputs are 0 before the next edge and `code_o` keeps its prior value. A subsequent load of 9 completes normally.

Source files
------------

// File: rtl/pudding_dac_loader.sv
// pudding_dac_loader
// Sequencer for the PUDDING DAC daisychain. A DAC code accepted over valid/ready
// is expanded to a CHAIN_LEN-bit thermometer pattern. That pattern is shifted
// into the chain, and then committed with a single chain->state transfer.
// Readback requests issue a single state->chain transfer instead.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   code_i/valid_i  requested active-cell count and its valid strobe
//   ready_o         loader idle, a load or readback can be accepted
//   rdbk_i          readback request, sampled only while idle
//   datum_o,shift_o serial data / shift enable to the chain
//   transfer_o      transfer strobe to the chain; dir_o selects its direction
//                   (1 = chain->state, 0 = state->chain)
//   done_o          one-cycle completion pulse
//   code_o          last committed, clamped code
module pudding_dac_loader #(
  parameter int CHAIN_LEN = 128,
  parameter int CODE_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              rdbk_i,
  output logic              datum_o,
  output logic              shift_o,
  output logic              transfer_o,
  output logic              dir_o,
  output logic              done_o,
  output logic [CODE_W-1:0] code_o
);
  localparam int KW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CODE_W-1:0] LEN_C  = CODE_W'(CHAIN_LEN);
  localparam logic [KW-1:0]     K_LAST = KW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CODE_W-1:0] code_q, code_d;      // clamped code of the load in flight
  logic              rdbk_q, rdbk_d;      // current XFER is a readback
  logic              datum_q, datum_d;
  logic              shift_q, shift_d;
  logic              transfer_q, transfer_d;
  logic              dir_q, dir_d;
  logic              done_q, done_d;
  logic [CODE_W-1:0] code_o_q, code_o_d;
  logic [CODE_W-1:0] code_clamp;

  // Shift position pos carries a one once the leading CHAIN_LEN-c zeros are out,
  // so the first bit shifted ends up at the far end of the chain.
  function automatic logic bit_on(input logic [KW-1:0] pos, input logic [CODE_W-1:0] c);
    return CODE_W'(pos) >= (LEN_C - c);
  endfunction

  assign code_clamp = (code_i > LEN_C) ? LEN_C : code_i;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    code_d     = code_q;
    rdbk_d     = rdbk_q;
    datum_d    = 1'b0;
    shift_d    = 1'b0;
    transfer_d = 1'b0;
    dir_d      = dir_q;        // direction holds between transfers
    done_d     = 1'b0;
    code_o_d   = code_o_q;
    // Outputs are computed for the state being entered, so every control pin
    // is a flop and lines up with the state it belongs to.
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin     // a load wins over a simultaneous readback
          code_d  = code_clamp;
          k_d     = '0;
          rdbk_d  = 1'b0;
          state_d = SHIFT;
          shift_d = 1'b1;
          datum_d = bit_on('0, code_clamp);
        end else if (rdbk_i) begin
          rdbk_d     = 1'b1;
          state_d    = XFER;
          transfer_d = 1'b1;
          dir_d      = 1'b0;
        end
      end
      SHIFT: begin
        if (k_q == K_LAST) begin
          state_d    = XFER;
          transfer_d = 1'b1;
          dir_d      = 1'b1;
          code_o_d   = code_q;  // committed together with the transfer pulse
        end else begin
          k_d     = k_q + KW'(1);
          shift_d = 1'b1;
          datum_d = bit_on(k_q + KW'(1), code_q);
        end
      end
      XFER: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      code_q     <= '0;
      rdbk_q     <= 1'b0;
      datum_q    <= 1'b0;
      shift_q    <= 1'b0;
      transfer_q <= 1'b0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      code_o_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      code_q     <= code_d;
      rdbk_q     <= rdbk_d;
      datum_q    <= datum_d;
      shift_q    <= shift_d;
      transfer_q <= transfer_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      code_o_q   <= code_o_d;
    end
  end

  assign ready_o    = (state_q == IDLE) & ~rst;
  assign datum_o    = datum_q;
  assign shift_o    = shift_q;
  assign transfer_o = transfer_q;
  assign dir_o      = dir_q;
  assign done_o     = done_q;
  assign code_o     = code_o_q;
endmodule

// File: tb/tb_pudding_dac_loader.sv
// Directed bench for pudding_dac_loader. A behavioural daisychain model sits on
// the control pins: shift moves datum into bit 0, and transfer has priority over
// shift. The bench checks chain/state contents, pulse counts and cycle latencies.
module tb_pudding_dac_loader;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code_i = '0;
  logic       valid_i = 1'b0;
  logic       rdbk_i = 1'b0;
  logic       ready_o, datum_o, shift_o, transfer_o, dir_o, done_o;
  logic [7:0] code_o;

  int n_tests = 0;
  int n_fail  = 0;

  pudding_dac_loader #(.CHAIN_LEN(128), .CODE_W(8)) dut (
    .clk(clk), .rst(rst), .code_i(code_i), .valid_i(valid_i), .ready_o(ready_o),
    .rdbk_i(rdbk_i), .datum_o(datum_o), .shift_o(shift_o), .transfer_o(transfer_o),
    .dir_o(dir_o), .done_o(done_o), .code_o(code_o)
  );

  always #5 clk = ~clk;

  // chain model and event monitor
  logic [127:0] chain_m = '0;
  logic [127:0] state_m = '0;
  logic         scramble = 1'b0;
  int cyc = 0, shift_n = 0, ones_n = 0, xl_n = 0, xr_n = 0, ovl_n = 0, acc_n = 0;
  int xfer_cyc = 0, done_cyc = 0, acc_cyc = 0, prev_acc = 0, rb_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (scramble) chain_m <= '1;
    else if (transfer_o) begin
      if (dir_o) state_m <= chain_m;
      else       chain_m <= state_m;
    end else if (shift_o) chain_m <= {chain_m[126:0], datum_o};
    if (shift_o) begin
      shift_n <= shift_n + 1;
      ones_n  <= ones_n + int'(datum_o);
    end
    if (transfer_o) begin
      xfer_cyc <= cyc;
      if (dir_o) xl_n <= xl_n + 1;
      else       xr_n <= xr_n + 1;
    end
    if (done_o) done_cyc <= cyc;
    if (shift_o && transfer_o) ovl_n <= ovl_n + 1;
    if (ready_o && valid_i) begin
      prev_acc <= acc_cyc;
      acc_cyc  <= cyc;
      acc_n    <= acc_n + 1;
    end else if (ready_o && rdbk_i) rb_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready_o && n < 300) begin @(negedge clk); n++; end
    chk("ready_timeout", 128'(ready_o), 128'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done_o && n < 300) begin @(negedge clk); n++; end
    chk("done_timeout", 128'(done_o), 128'(1));
    @(negedge clk);
  endtask

  task automatic load(input logic [7:0] c, input logic rb);
    wait_ready();
    code_i = c; valid_i = 1'b1; rdbk_i = rb;
    @(posedge clk); #1;
    valid_i = 1'b0; rdbk_i = 1'b0; code_i = 8'hA5;  // code_i is free after acceptance
    wait_done();
  endtask

  int s0, o0, l0, r0, a0;
  task automatic snap();
    s0 = shift_n; o0 = ones_n; l0 = xl_n; r0 = xr_n; a0 = acc_n;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_ready", 128'(ready_o), 128'(0));
    chk("rst_ctrl", 128'({datum_o, shift_o, transfer_o, dir_o, done_o}), 128'(0));
    chk("rst_code", 128'(code_o), 128'(0));
    @(negedge clk); rst = 1'b0;

    // load 5: 123 zeros then 5 ones, one transfer, fixed latencies
    snap();
    load(8'd5, 1'b0);
    chk("l5_shifts", 128'(shift_n - s0), 128'(128));
    chk("l5_ones", 128'(ones_n - o0), 128'(5));
    chk("l5_xfer_load", 128'(xl_n - l0), 128'(1));
    chk("l5_xfer_rdbk", 128'(xr_n - r0), 128'(0));
    chk("l5_xfer_lat", 128'(xfer_cyc - acc_cyc), 128'(129));
    chk("l5_done_lat", 128'(done_cyc - acc_cyc), 128'(130));
    chk("l5_state", state_m, 128'h1F);
    chk("l5_code", 128'(code_o), 128'(5));
    chk("l5_dir_hold", 128'(dir_o), 128'(1));
    chk("l5_ready", 128'(ready_o), 128'(1));

    // code 0: all-zero pattern, transfer still issued
    snap();
    load(8'd0, 1'b0);
    chk("l0_xfer", 128'(xl_n - l0), 128'(1));
    chk("l0_state", state_m, 128'h0);
    chk("l0_code", 128'(code_o), 128'(0));

    // async reset in SHIFT at k=60; code_o was 0 before this load
    wait_ready();
    code_i = 8'd77; valid_i = 1'b1;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("ar_in_shift", 128'({shift_o, datum_o}), 128'(2'b11));
    #1 rst = 1'b1;
    #1;
    chk("ar_ctrl", 128'({datum_o, shift_o, transfer_o, dir_o, done_o}), 128'(0));
    chk("ar_ready", 128'(ready_o), 128'(0));
    chk("ar_code", 128'(code_o), 128'(0));
    @(negedge clk); rst = 1'b0;
    snap();
    load(8'd9, 1'b0);
    chk("ar_l9_shifts", 128'(shift_n - s0), 128'(128));
    chk("ar_l9_state", state_m, 128'h1FF);
    chk("ar_l9_code", 128'(code_o), 128'(9));

    // clamp cases
    load(8'd128, 1'b0);
    chk("l128_state", state_m, '1);
    chk("l128_code", 128'(code_o), 128'(128));
    load(8'd200, 1'b0);
    chk("l200_state", state_m, '1);
    chk("l200_code", 128'(code_o), 128'(128));

    // back-to-back with valid held: 3 then 7
    snap();
    wait_ready();
    code_i = 8'd3; valid_i = 1'b1;
    @(posedge clk); #1; code_i = 8'd7;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (acc_n == a0 + 2) break;
    end
    valid_i = 1'b0;
    chk("b2b_accepts", 128'(acc_n - a0), 128'(2));
    chk("b2b_spacing", 128'(acc_cyc - prev_acc), 128'(131));
    wait_done();
    chk("b2b_xfers", 128'(xl_n - l0), 128'(2));
    chk("b2b_state", state_m, 128'h7F);
    chk("b2b_code", 128'(code_o), 128'(7));

    // readback after loading 10; chain scrambled first so the copy is visible
    load(8'd10, 1'b0);
    @(negedge clk) scramble = 1'b1;
    @(negedge clk) scramble = 1'b0;
    chk("rb_scrambled", chain_m, '1);
    snap();
    wait_ready();
    rdbk_i = 1'b1;
    @(posedge clk); #1; rdbk_i = 1'b0;
    wait_done();
    chk("rb_xfer_rdbk", 128'(xr_n - r0), 128'(1));
    chk("rb_xfer_load", 128'(xl_n - l0), 128'(0));
    chk("rb_shifts", 128'(shift_n - s0), 128'(0));
    chk("rb_xfer_lat", 128'(xfer_cyc - rb_cyc), 128'(1));
    chk("rb_done_lat", 128'(done_cyc - rb_cyc), 128'(2));
    chk("rb_chain", chain_m, 128'h3FF);
    chk("rb_code", 128'(code_o), 128'(10));
    chk("rb_dir_hold", 128'(dir_o), 128'(0));

    // simultaneous valid and rdbk: load wins, readback dropped
    snap();
    load(8'd4, 1'b1);
    repeat (4) @(negedge clk);
    chk("sim_xfer_load", 128'(xl_n - l0), 128'(1));
    chk("sim_xfer_rdbk", 128'(xr_n - r0), 128'(0));
    chk("sim_state", state_m, 128'hF);
    chk("sim_code", 128'(code_o), 128'(4));

    chk("no_overlap", 128'(ovl_n), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
